// File: rtl/rfa_rr_scheduler.sv
// Round-robin scheduler sharing one register-file access port among 16 requesters.
// Each grant is registered, one-hot, and held for HOLD_CYCLES cycles.
module rfa_rr_scheduler #(
   parameter int HOLD_CYCLES = 4,
   parameter int PTR_RESET   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req,
   output logic [15:0] gnt,
   output logic        gnt_valid,
   output logic [3:0]  gnt_id,
   output logic        gnt_done,
   output logic [3:0]  ptr
);
   // state | meaning
   // IDLE  | no grant held, arbitrate whenever req != 0
   // HOLD  | grant held; cnt counts down to 0 on the last cycle
   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [3:0] CNT_LOAD  = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0] PTR_INIT  = 4'(PTR_RESET);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] gnt_q, gnt_d;
   logic [3:0]  id_q, id_d;
   logic [3:0]  ptr_q, ptr_d;

   logic [15:0] rot1, rot2, rot4, rot8;
   logic [15:0] pick_oh;
   logic [15:0] un1, un2, un4, un8;
   logic [3:0]  pick_idx;
   logic [3:0]  win_id;
   logic        arb;

   // Rotate req right by ptr so the search always starts at bit 0.
   always_comb begin
      rot1 = ptr_q[0] ? {req[0],     req[15:1]}  : req;
      rot2 = ptr_q[1] ? {rot1[1:0],  rot1[15:2]} : rot1;
      rot4 = ptr_q[2] ? {rot2[3:0],  rot2[15:4]} : rot2;
      rot8 = ptr_q[3] ? {rot4[7:0],  rot4[15:8]} : rot4;
   end

   always_comb begin
      pick_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (rot8[i]) pick_idx = 4'(i);
      end
      pick_oh = 16'd1 << pick_idx;
   end

   // Un-rotate the picked bit back into requester space.
   always_comb begin
      un1 = ptr_q[0] ? {pick_oh[14:0], pick_oh[15]}    : pick_oh;
      un2 = ptr_q[1] ? {un1[13:0],     un1[15:14]}     : un1;
      un4 = ptr_q[2] ? {un2[11:0],     un2[15:12]}     : un2;
      un8 = ptr_q[3] ? {un4[7:0],      un4[15:8]}      : un4;
      win_id = pick_idx + ptr_q;
   end

   assign arb = (state_q == IDLE) || (cnt_q == 4'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      if (arb) begin
         if (req != 16'd0) begin
            state_d = HOLD;
            cnt_d   = CNT_LOAD;
            gnt_d   = un8;
            id_d    = win_id;
            ptr_d   = win_id + 4'd1;
         end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            gnt_d   = 16'd0;
            id_d    = 4'd0;
         end
      end else begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         gnt_q   <= 16'd0;
         id_q    <= 4'd0;
         ptr_q   <= PTR_INIT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = (state_q == HOLD);
   assign gnt_id    = id_q;
   assign gnt_done  = (state_q == HOLD) && (cnt_q == 4'd0);
   assign ptr       = ptr_q;

endmodule

// File: tb/tb_rfa_rr_scheduler.sv
// Bench for rfa_rr_scheduler: directed scenarios plus random traffic, each cycle
// compared against a cycle-level reference model of the arbitration rules.
module tb_rfa_rr_scheduler;
   localparam int HOLD = 4;
   localparam int PRST = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] req;
   logic [15:0] gnt;
   logic        gnt_valid;
   logic [3:0]  gnt_id;
   logic        gnt_done;
   logic [3:0]  ptr;

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit  m_busy;
   int  m_left;
   int  m_id;
   int  m_ptr;

   rfa_rr_scheduler #(.HOLD_CYCLES(HOLD), .PTR_RESET(PRST)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .gnt_done  (gnt_done),
      .ptr       (ptr)
   );

   always #5 clk = ~clk;

   task automatic model_edge(input logic r, input logic [15:0] rq);
      int w;
      if (r) begin
         m_busy = 0; m_left = 0; m_id = 0; m_ptr = PRST;
      end else if (!m_busy || m_left == 1) begin
         if (rq != 16'd0) begin
            w = -1;
            for (int k = 0; k < 16; k++) begin
               if (w < 0 && rq[(m_ptr + k) % 16]) w = (m_ptr + k) % 16;
            end
            m_id = w; m_ptr = (w + 1) % 16; m_left = HOLD; m_busy = 1;
         end else begin
            m_busy = 0; m_left = 0; m_id = 0;
         end
      end else begin
         m_left = m_left - 1;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [15:0] e_gnt;
      logic        e_val, e_done;
      logic [3:0]  e_id, e_ptr;
      e_gnt  = m_busy ? (16'd1 << m_id) : 16'd0;
      e_val  = m_busy;
      e_id   = m_busy ? 4'(m_id) : 4'd0;
      e_done = m_busy && (m_left == 1);
      e_ptr  = 4'(m_ptr);
      checks++;
      assert (gnt === e_gnt) else begin
         failures++; $error("FAIL %s gnt observed=%h expected=%h", tag, gnt, e_gnt);
      end
      checks++;
      assert (gnt_valid === e_val) else begin
         failures++; $error("FAIL %s gnt_valid observed=%b expected=%b", tag, gnt_valid, e_val);
      end
      checks++;
      assert (gnt_id === e_id) else begin
         failures++; $error("FAIL %s gnt_id observed=%0d expected=%0d", tag, gnt_id, e_id);
      end
      checks++;
      assert (gnt_done === e_done) else begin
         failures++; $error("FAIL %s gnt_done observed=%b expected=%b", tag, gnt_done, e_done);
      end
      checks++;
      assert (ptr === e_ptr) else begin
         failures++; $error("FAIL %s ptr observed=%0d expected=%0d", tag, ptr, e_ptr);
      end
   endtask

   task automatic step(input string tag, input logic r, input logic [15:0] rq);
      @(negedge clk);
      rst = r;
      req = rq;
      @(posedge clk);
      model_edge(r, rq);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      logic [15:0] rq;
      rst = 1'b1;
      req = 16'hFFFF;
      m_busy = 0; m_left = 0; m_id = 0; m_ptr = PRST;

      // T1 reset with all requests pending
      step("t1_reset", 1'b1, 16'hFFFF);
      step("t1_reset", 1'b1, 16'hFFFF);
      checks++;
      assert (gnt === 16'd0 && ptr === 4'd0) else begin
         failures++; $error("FAIL t1_direct gnt=%h ptr=%0d expected gnt=0000 ptr=0", gnt, ptr);
      end

      // T2 full load: 0..15 then 0 again, back to back
      for (int i = 0; i < 17 * HOLD; i++) step("t2_full", 1'b0, 16'hFFFF);

      // T3 fairness between the two ends
      step("t3_rst", 1'b1, 16'h0000);
      for (int i = 0; i < 4 * HOLD; i++) step("t3_fair", 1'b0, 16'h8001);

      // T4 wrap from ptr=14
      step("t4_rst", 1'b1, 16'h0000);
      step("t4_setup", 1'b0, 16'h2000);
      for (int i = 0; i < HOLD; i++) step("t4_drain", 1'b0, 16'h0000);
      step("t4_wrap", 1'b0, 16'h0003);
      checks++;
      assert (gnt === 16'h0001 && gnt_id === 4'd0 && ptr === 4'd1) else begin
         failures++; $error("FAIL t4_direct gnt=%h id=%0d ptr=%0d expected 0001/0/1", gnt, gnt_id, ptr);
      end
      for (int i = 0; i < HOLD; i++) step("t4_tail", 1'b0, 16'h0000);

      // T5 granted requester drops mid-hold
      step("t5_rst", 1'b1, 16'h0000);
      step("t5_grant", 1'b0, 16'h0020);
      step("t5_hold", 1'b0, 16'h0020);
      for (int i = 0; i < HOLD + 1; i++) step("t5_drop", 1'b0, 16'h0000);
      checks++;
      assert (gnt_valid === 1'b0) else begin
         failures++; $error("FAIL t5_direct gnt_valid observed=%b expected=0", gnt_valid);
      end

      // T6 reset in the middle of a grant
      step("t6_rst", 1'b1, 16'h0000);
      step("t6_grant", 1'b0, 16'h0200);
      step("t6_hold", 1'b0, 16'h0200);
      step("t6_midrst", 1'b1, 16'h0200);
      for (int i = 0; i < 3 * HOLD; i++) step("t6_restart", 1'b0, 16'hFFFF);

      // random traffic, including sparse, dense and occasional resets
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0: rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
            1: rq = 16'($urandom);
            2: rq = 16'd1 << $urandom_range(0, 15);
            default: rq = 16'd0;
         endcase
         step("rand", ($urandom_range(0, 60) == 0), rq);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
